// File: rtl/lag_pl_output_credit_tracker.sv
// Transmit-side per-PL output register and downstream credit tracker.
// Each physical lane (PL) registers its outgoing flit. It also keeps a credit
// counter for the downstream buffer and records whether a packet owns the lane.
// Optional feature macro: LAG_CREDIT_BYPASS_EN. When it is defined, a credit
// returned in the current cycle can be spent in that same cycle.

package lag_pl_output_credit_tracker_pkg;

    typedef struct packed {
        logic head;
        logic tail;
    } flit_ctrl_t;

    typedef struct packed {
        flit_ctrl_t  control;
        logic [15:0] data;
    } flit_t;

endpackage

module lag_pl_output_credit_tracker
    import lag_pl_output_credit_tracker_pkg::*;
#(
    parameter int num_pls       = 4,
    parameter int buffer_length = 8,
    parameter int cnt_w         = $clog2(buffer_length + 1),
    parameter bit err_fatal_en  = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  flit_t [num_pls-1:0]            flit_in,
    input  logic  [num_pls-1:0]            flit_in_valid,
    input  logic  [num_pls-1:0]            credit_in,
    input  logic  [num_pls-1:0]            pl_alloc,
    output flit_t [num_pls-1:0]            flit_out,
    output logic  [num_pls-1:0]            flit_out_valid,
    output logic  [num_pls-1:0]            pl_free,
    output logic  [num_pls-1:0]            pl_credit_avail,
    output logic  [num_pls-1:0][cnt_w-1:0] credit_count,
    output logic                           protocol_error
);

    localparam logic [cnt_w-1:0] CNT_MAX = cnt_w'(buffer_length);

    logic [num_pls-1:0]            tail_send;
    logic [num_pls-1:0]            illegal_send;
    logic [num_pls-1:0]            credit_overflow;
    logic [num_pls-1:0]            realloc_busy;
    logic [num_pls-1:0]            orphan_flit;
    logic [num_pls-1:0]            err_vec;
    logic [num_pls-1:0]            free_d;
    logic [num_pls-1:0][cnt_w-1:0] cnt_d;

    // Per-PL credit availability, error detection and next-state computation
    always_comb begin
        pl_credit_avail = '0;
        tail_send       = '0;
        illegal_send    = '0;
        credit_overflow = '0;
        realloc_busy    = '0;
        orphan_flit     = '0;
        free_d          = pl_free;
        cnt_d           = credit_count;
        for (int unsigned i = 0; i < num_pls; i++) begin
`ifdef LAG_CREDIT_BYPASS_EN
            pl_credit_avail[i] = (credit_count[i] != '0) | credit_in[i];
`else
            pl_credit_avail[i] = (credit_count[i] != '0);
`endif
            tail_send[i]       = flit_in_valid[i] & flit_in[i].control.tail;
            illegal_send[i]    = flit_in_valid[i] & ~pl_credit_avail[i];
            credit_overflow[i] = credit_in[i] & ~flit_in_valid[i] &
                                 (credit_count[i] == CNT_MAX);
            realloc_busy[i]    = pl_alloc[i] & ~pl_free[i] & ~tail_send[i];
            orphan_flit[i]     = flit_in_valid[i] & ~flit_in[i].control.tail &
                                 pl_free[i] & ~pl_alloc[i];

            // When a send and a returned credit meet, the count holds. This also
            // covers an illegal send at zero: the arriving credit absorbs it.
            case ({flit_in_valid[i], credit_in[i]})
                2'b10:   cnt_d[i] = (credit_count[i] == '0) ? '0
                                    : credit_count[i] - 1'b1;
                2'b01:   cnt_d[i] = (credit_count[i] == CNT_MAX) ? CNT_MAX
                                    : credit_count[i] + 1'b1;
                default: cnt_d[i] = credit_count[i];
            endcase

            // A tail send releases the lane and has priority over a new grant.
            if (tail_send[i]) begin
                free_d[i] = 1'b1;
            end else if (pl_alloc[i]) begin
                free_d[i] = 1'b0;
            end
        end
        err_vec = illegal_send | credit_overflow | realloc_busy | orphan_flit;
    end

    // Output flit registers: capture on valid, hold otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flit_out       <= '0;
            flit_out_valid <= '0;
        end else begin
            flit_out_valid <= flit_in_valid;
            for (int unsigned i = 0; i < num_pls; i++) begin
                if (flit_in_valid[i]) begin
                    flit_out[i] <= flit_in[i];
                end
            end
        end
    end

    // Credit counters, lane ownership and the sticky error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < num_pls; i++) begin
                credit_count[i] <= CNT_MAX;
            end
            pl_free        <= '1;
            protocol_error <= 1'b0;
        end else begin
            credit_count   <= cnt_d;
            pl_free        <= free_d;
            protocol_error <= protocol_error | (|err_vec);
        end
    end

`ifndef SYNTHESIS
    // Simulation-only protocol checker; err_fatal_en lets a bench provoke errors deliberately
    always @(posedge clk) begin
        if (rst_n && err_fatal_en) begin
            assert (err_vec == '0)
            else begin
                $display("lag_pl_output_credit_tracker protocol error: illegal=%b overflow=%b realloc=%b orphan=%b",
                         illegal_send, credit_overflow, realloc_busy, orphan_flit);
                $fatal(1, "lag_pl_output_credit_tracker protocol error");
            end
        end
    end
`endif

endmodule

// File: tb/tb_lag_pl_output_credit_tracker.sv
// Directed, table-driven bench for lag_pl_output_credit_tracker.
// The expected values depend on whether LAG_CREDIT_BYPASS_EN is defined.
module tb_lag_pl_output_credit_tracker;
    import lag_pl_output_credit_tracker_pkg::*;

`ifdef LAG_CREDIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    flit_t [3:0]       flit_in;
    logic  [3:0]       flit_in_valid;
    logic  [3:0]       credit_in;
    logic  [3:0]       pl_alloc;
    flit_t [3:0]       flit_out;
    logic  [3:0]       flit_out_valid;
    logic  [3:0]       pl_free;
    logic  [3:0]       pl_credit_avail;
    logic  [3:0][3:0]  credit_count;
    logic              protocol_error;

    int tests = 0;
    int fails = 0;

    flit_t [3:0] last_flit;

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  tail;
        logic [3:0]  cred;
        logic [3:0]  alloc;
        logic [3:0]  exp_free;
        logic [3:0]  exp_avail;
        logic [3:0]  exp_ov;
        logic [15:0] exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t vecs [20];

    lag_pl_output_credit_tracker #(
        .num_pls       (4),
        .buffer_length (8),
        .err_fatal_en  (1'b0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flit_in         (flit_in),
        .flit_in_valid   (flit_in_valid),
        .credit_in       (credit_in),
        .pl_alloc        (pl_alloc),
        .flit_out        (flit_out),
        .flit_out_valid  (flit_out_valid),
        .pl_free         (pl_free),
        .pl_credit_avail (pl_credit_avail),
        .credit_count    (credit_count),
        .protocol_error  (protocol_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        flit_in       = '0;
        flit_in_valid = '0;
        credit_in     = '0;
        pl_alloc      = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_flit = '0;
        check("rst_cnt",   32'(credit_count),    32'h8888);
        check("rst_free",  32'(pl_free),         32'hF);
        check("rst_avail", 32'(pl_credit_avail), 32'hF);
        check("rst_ov",    32'(flit_out_valid),  32'h0);
        check("rst_err",   32'(protocol_error),  32'h0);
        check("rst_flit",  32'(|flit_out),       32'h0);
    endtask

    // Drive one cycle, release the inputs, then sample so combinational avail sees idle inputs
    task automatic cycle(input logic [3:0] vld, input logic [3:0] tail,
                         input logic [3:0] cred, input logic [3:0] alloc, input int k);
        for (int i = 0; i < 4; i++) begin
            flit_in[i].control.head = 1'b0;
            flit_in[i].control.tail = tail[i];
            flit_in[i].data         = 16'(k * 16 + i);
            if (vld[i]) last_flit[i] = flit_in[i];
        end
        flit_in_valid = vld;
        credit_in     = cred;
        pl_alloc      = alloc;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        last_flit = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("idle_cnt",   32'(credit_count),    32'h8888);
            check("idle_free",  32'(pl_free),         32'hF);
            check("idle_avail", 32'(pl_credit_avail), 32'hF);
            check("idle_ov",    32'(flit_out_valid),  32'h0);
            check("idle_err",   32'(protocol_error),  32'h0);
        end

        //                vld      tail     cred     alloc    free     avail    ov       cnt       err
        vecs[0]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b1100, 4'b1111, 4'b0000, 16'h8888, 1'b0};
        vecs[1]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b1111, 4'b0011, 16'h8877, 1'b0};
        vecs[2]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b1111, 4'b0011, 16'h8866, 1'b0};
        vecs[3]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b1111, 4'b0011, 16'h8855, 1'b0};
        vecs[4]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b1111, 4'b0011, 16'h8844, 1'b0};
        vecs[5]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b1111, 4'b0011, 16'h8833, 1'b0};
        vecs[6]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b1111, 4'b0001, 16'h8832, 1'b0};
        vecs[7]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b1111, 4'b0001, 16'h8831, 1'b0};
        vecs[8]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b1101, 4'b1110, 4'b0001, 16'h8830, 1'b0};
        vecs[9]  = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b1101, 4'b1110, 4'b0010, 16'h8830, 1'b0};
        vecs[10] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b1101, 4'b1110, 4'b0010, 16'h8830, 1'b0};
        vecs[11] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b1101, 4'b1110, 4'b0010, 16'h8830, 1'b0};
        vecs[12] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b1101, 4'b1110, 4'b0010, 16'h8830, 1'b0};
        vecs[13] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b1101, 4'b1110, 4'b0000, 16'h8840, 1'b0};
        vecs[14] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b1101, 4'b1110, 4'b0000, 16'h8850, 1'b0};
        vecs[15] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b1101, 4'b1110, 4'b0100, 16'h8750, 1'b0};
        vecs[16] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b1111, 4'b1110, 4'b0010, 16'h8740, 1'b0};
        vecs[17] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1111, 4'b1110, 4'b0001, 16'h8740, !BYP};
        vecs[18] = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b1111, 4'b1110, 4'b0000, 16'h8740, 1'b1};
        vecs[19] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1110, 4'b0000, 16'h8740, 1'b1};

        for (int k = 0; k < 20; k++) begin
            cycle(vecs[k].vld, vecs[k].tail, vecs[k].cred, vecs[k].alloc, k);
            check($sformatf("v%0d_cnt", k),   32'(credit_count),    32'(vecs[k].exp_cnt));
            check($sformatf("v%0d_free", k),  32'(pl_free),         32'(vecs[k].exp_free));
            check($sformatf("v%0d_avail", k), 32'(pl_credit_avail), 32'(vecs[k].exp_avail));
            check($sformatf("v%0d_ov", k),    32'(flit_out_valid),  32'(vecs[k].exp_ov));
            check($sformatf("v%0d_err", k),   32'(protocol_error),  32'(vecs[k].exp_err));
            for (int i = 0; i < 4; i++) begin
                check($sformatf("v%0d_flit%0d", k, i), 32'(flit_out[i]), 32'(last_flit[i]));
            end
        end

        // A reset in the middle of operation restores credits and clears the sticky error
        do_reset();

        // Allocating a lane that is already busy is an error, and the lane stays busy
        cycle(4'b0000, 4'b0000, 4'b0000, 4'b0010, 100);
        check("alloc1_err",  32'(protocol_error), 32'h0);
        check("alloc1_free", 32'(pl_free),        32'hD);
        cycle(4'b0000, 4'b0000, 4'b0000, 4'b0010, 101);
        check("realloc_err",  32'(protocol_error), 32'h1);
        check("realloc_free", 32'(pl_free),        32'hD);
        do_reset();

        // A non-tail flit on a free lane with no grant is an error but is still forwarded
        cycle(4'b0100, 4'b0000, 4'b0000, 4'b0000, 102);
        check("orphan_err",  32'(protocol_error), 32'h1);
        check("orphan_cnt",  32'(credit_count),   32'h8788);
        check("orphan_ov",   32'(flit_out_valid), 32'h4);
        check("orphan_flit", 32'(flit_out[2]),    32'(last_flit[2]));
        do_reset();

        // Drain PL3 to zero, then send with no credit: counter pins at 0 and error is raised
        cycle(4'b0000, 4'b0000, 4'b0000, 4'b1000, 103);
        for (int n = 0; n < 8; n++) cycle(4'b1000, 4'b0000, 4'b0000, 4'b0000, 104 + n);
        check("drain_cnt", 32'(credit_count), 32'h0888);
        check("drain_err", 32'(protocol_error), 32'h0);
        cycle(4'b1000, 4'b0000, 4'b0000, 4'b0000, 120);
        check("under_cnt",  32'(credit_count),   32'h0888);
        check("under_err",  32'(protocol_error), 32'h1);
        check("under_flit", 32'(flit_out[3]),    32'(last_flit[3]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
